scan_sequencer: RTL and testbench

- Frame-scan controller for the image datapath.
- Walks a pixel cursor (x, y) across a rectangular frame of runtime-programmable size, one pixel per accepted beat.
- Downstream consumer sees a valid/ready stream of coordinates with line/frame markers.
- Replaces free-running strobe chaining with a start/abort-controlled state machine, a backpressure-safe cursor, a done pulse and a frame counter.

---
 rtl/scan_pkg.sv | 14 +
 rtl/scan_axis_counter.sv | 39 +++
 rtl/scan_sequencer.sv | 141 ++++++++++++++
 tb/tb_scan_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and default widths for the frame-scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    localparam int unsigned SCAN_XW  = 4;
    localparam int unsigned SCAN_YW  = 4;
    localparam int unsigned SCAN_FCW = 8;

endpackage

// File: rtl/scan_axis_counter.sv
// One axis of the scan cursor: counts 0..max, wraps to 0 on inc at max.
// Clear takes priority over increment.
module scan_axis_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_q, count_d;

    // Next count: clear, wrap or step.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = at_max ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == max);

endmodule

// File: rtl/scan_sequencer.sv
// Frame-scan controller: walks (x, y) over a programmable frame, one pixel per
// accepted beat, with start/abort control, done pulse and frame counter.
// Optional macro SCAN_SEQUENCER_CONTINUOUS_EN: start during DONE chains the next
// frame directly, leaving a single non-valid gap cycle.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned XW  = SCAN_XW,
    parameter int unsigned YW  = SCAN_YW,
    parameter int unsigned FCW = SCAN_FCW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [XW-1:0]  h_max,
    input  logic [YW-1:0]  v_max,
    input  logic           pix_ready,
    output logic           pix_valid,
    output logic [XW-1:0]  pix_x,
    output logic [YW-1:0]  pix_y,
    output logic           line_last,
    output logic           frame_last,
    output logic           busy,
    output logic           frame_done,
    output logic [FCW-1:0] frame_count
);

    scan_state_t    state_q, state_d;
    logic [XW-1:0]  hm_q;
    logic [YW-1:0]  vm_q;
    logic [FCW-1:0] fc_q;
    logic           load;
    logic           transfer;
    logic           clr;
    logic           x_at_max, y_at_max;

    assign transfer = (state_q == SCAN) && pix_ready;
    // Abort or a new frame both restart the cursor at the origin.
    assign clr      = abort || load;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and frame-size latch enable; abort overrides everything.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SCAN;
                    load    = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (transfer && x_at_max && y_at_max) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef SCAN_SEQUENCER_CONTINUOUS_EN
                if (start && !abort) begin
                    state_d = SCAN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state and cursor.
    always_comb begin
        pix_valid  = (state_q == SCAN);
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
        line_last  = pix_valid && x_at_max;
        frame_last = line_last && y_at_max;
    end

    // Frame size is captured only when a scan is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hm_q <= '0;
            vm_q <= '0;
        end else if (load) begin
            hm_q <= h_max;
            vm_q <= v_max;
        end
    end

    // Completed-frame counter, bumped as DONE retires unless aborted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_q <= '0;
        end else if (state_q == DONE && !abort) begin
            fc_q <= fc_q + FCW'(1);
        end
    end

    assign frame_count = fc_q;

    scan_axis_counter #(
        .W (XW)
    ) u_x_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (transfer),
        .clr    (clr),
        .max    (hm_q),
        .count  (pix_x),
        .at_max (x_at_max)
    );

    // y steps only when a line completes.
    scan_axis_counter #(
        .W (YW)
    ) u_y_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (transfer && x_at_max),
        .clr    (clr),
        .max    (vm_q),
        .count  (pix_y),
        .at_max (y_at_max)
    );

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: the driver pushes the expected beat list
// of each accepted frame; a negedge monitor pops and compares on every transfer.
module tb_scan_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] h_max;
    logic [3:0] v_max;
    logic       pix_ready;
    logic       pix_valid;
    logic [3:0] pix_x;
    logic [3:0] pix_y;
    logic       line_last;
    logic       frame_last;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_count;

    scan_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .h_max       (h_max),
        .v_max       (v_max),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .line_last   (line_last),
        .frame_last  (frame_last),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit ll;
        bit fl;
    } beat_t;

    beat_t      exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         xfers = 0;
    int         vcycles = 0;
    int         exp_beats = 0;
    logic [7:0] exp_count = 8'd0;
    bit         last_final = 1'b0;
    bit         held = 1'b0;
    logic [3:0] hx, hy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: transfer scoreboard, stall stability and done-pulse timing.
    always @(negedge clk) begin
        if (reset) begin
            last_final = 1'b0;
            held       = 1'b0;
        end else begin
            chk("frame_done_timing", {31'd0, frame_done}, {31'd0, last_final});
            if (pix_valid) vcycles++;
            if (held && pix_valid) begin
                chk("stall_x", {28'd0, pix_x}, {28'd0, hx});
                chk("stall_y", {28'd0, pix_y}, {28'd0, hy});
            end
            last_final = 1'b0;
            if (pix_valid && pix_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_x", {28'd0, pix_x}, e.x);
                    chk("beat_y", {28'd0, pix_y}, e.y);
                    chk("line_last", {31'd0, line_last}, {31'd0, e.ll});
                    chk("frame_last", {31'd0, frame_last}, {31'd0, e.fl});
                    last_final = e.fl;
                end
            end
            held = pix_valid && !pix_ready;
            hx   = pix_x;
            hy   = pix_y;
        end
    end

    // Reference model: a frame is the row-major list of all (x, y) in the box.
    task automatic start_frame(input int hm, input int vm);
        h_max = 4'(hm);
        v_max = 4'(vm);
        start = 1'b1;
        for (int y = 0; y <= vm; y++) begin
            for (int x = 0; x <= hm; x++) begin
                beat_t b;
                b.x  = x;
                b.y  = y;
                b.ll = (x == hm);
                b.fl = (x == hm) && (y == vm);
                exp_q.push_back(b);
            end
        end
        exp_beats = (hm + 1) * (vm + 1);
        xfers     = 0;
        vcycles   = 0;
    endtask

    // Drive ready per mode with stray starts and size changes until frame_done.
    task automatic scan_until_done(input int mode);
        bit ok = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                chk("first_valid", {31'd0, pix_valid}, 32'd1);
                chk("first_xy", {24'd0, pix_x, pix_y}, 32'd0);
            end
            if (frame_done) begin
                ok = 1'b1;
                start = 1'b0;
                break;
            end
            start = ($urandom_range(0, 3) == 0);
            h_max = 4'($urandom);
            v_max = 4'($urandom);
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (cyc % 3 == 0);
                default: pix_ready = 1'($urandom);
            endcase
        end
        chk("frame_done_seen", {31'd0, ok}, 32'd1);
        start = 1'b0;
        chk("xfer_count", xfers, exp_beats);
        chk("queue_empty", exp_q.size(), 32'd0);
        if (mode == 0) chk("throughput", vcycles, exp_beats);
        if (ok) exp_count++;
    endtask

    task automatic finish_frame();
        @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, pix_valid}, 32'd0);
        chk("frame_count", {24'd0, frame_count}, {24'd0, exp_count});
    endtask

    task automatic run_frame(input int hm, input int vm, input int mode);
        start_frame(hm, vm);
        scan_until_done(mode);
        finish_frame();
    endtask

    initial begin
        bit         found;
        int         gap;
        logic [7:0] fc0;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        h_max = 4'd0;
        v_max = 4'd0;
        pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_markers", {30'd0, line_last, frame_last}, 32'd0);
        chk("rst_xy", {24'd0, pix_x, pix_y}, 32'd0);
        chk("rst_count", {24'd0, frame_count}, 32'd0);
        reset = 1'b0;

        // Full frame, then the same frame with 1,0,0 backpressure.
        run_frame(3, 2, 0);
        run_frame(3, 2, 1);

        // Abort while beat (2,1) is presented.
        start_frame(3, 2);
        found = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (pix_valid && pix_x == 4'd2 && pix_y == 4'd1) begin
                found = 1'b1;
                pix_ready = 1'b0;
                abort = 1'b1;
                break;
            end
            pix_ready = 1'b1;
        end
        chk("abort_reached", {31'd0, found}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid", {31'd0, pix_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_count", {24'd0, frame_count}, {24'd0, exp_count});
        run_frame(1, 1, 0);

        // Degenerate sizes.
        run_frame(0, 0, 0);
        run_frame(0, 3, 2);
        run_frame(3, 0, 2);

        // start+abort together in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("collide_busy", {31'd0, busy}, 32'd0);
        chk("collide_valid", {31'd0, pix_valid}, 32'd0);

        // Random sizes and random backpressure.
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(0, 5), $urandom_range(0, 5), 2);
        end

        // Gap from final transfer to next first valid beat, start held high.
        start_frame(2, 1);
        scan_until_done(0);
        pix_ready = 1'b0;
        start_frame(1, 2);
        gap = 0;
        for (int g = 1; g <= 5; g++) begin
            @(posedge clk);
            #1;
            if (pix_valid) begin
                gap = g;
                break;
            end
        end
        start = 1'b0;
`ifdef SCAN_SEQUENCER_CONTINUOUS_EN
        chk("restart_gap", gap, 32'd1);
`else
        chk("restart_gap", gap, 32'd2);
`endif
        scan_until_done(2);
        finish_frame();

        // 256 single-beat frames wrap the counter back to its start value.
        fc0 = exp_count;
        for (int i = 0; i < 256; i++) run_frame(0, 0, 0);
        chk("count_wrap", {24'd0, frame_count}, {24'd0, fc0});

        // Asynchronous reset mid-scan.
        start_frame(3, 3);
        repeat (5) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            pix_ready = 1'b1;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_xy", {24'd0, pix_x, pix_y}, 32'd0);
        chk("async_rst_count", {24'd0, frame_count}, 32'd0);
        exp_q.delete();
        exp_count = 8'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
